ps2_direction_decoder: RTL and testbench



---
 rtl/ps2_direction_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard front end for the snake core: synchronizes and glitch-filters
// KB_clk, receives 11-bit frames, and turns W/A/S/D make codes into a one-hot direction.
// Latency: stop-bit fall event -> code_valid +1 cycle -> direction/key_valid +1 cycle.
// Backpressure: none. PS/2 is free-running, so outputs are single-cycle pulses that cannot be stalled.
// Optional macro PS2_ARROW_KEYS_EN adds E0-prefixed arrow keys (75/6B/72/74).
// Ports: VGA_clk/reset_n (sync, active-low); KB_clk/KB_data raw async inputs;
//        direction/key_valid, scan_code/code_valid, frame_err outputs.
module ps2_direction_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       VGA_clk,
    input  logic       reset_n,
    input  logic       KB_clk,
    input  logic       KB_data,
    output logic [3:0] direction,
    output logic       key_valid,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]  clk_sync;
    logic [1:0]  data_sync;
    logic [3:0]  filt_cnt;
    logic        filt_clk;
    logic        fall;
    logic [1:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par_bit;
    logic [15:0] to_cnt;
    logic        break_flag;
    logic        ext_flag;
    logic        break_next;
    logic        ext_next;
    logic [3:0]  req;
    logic [3:0]  opposite;
    logic        accept;

    // Two-flop synchronizers; idle level of both PS/2 lines is high.
    always_ff @(posedge VGA_clk) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], KB_clk};
            data_sync <= {data_sync[0], KB_data};
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive samples disagree
    // with it; any agreeing sample restarts the count. fall is high in the same
    // cycle the filtered clock first reads 0.
    always_ff @(posedge VGA_clk) begin
        if (!reset_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] != filt_clk) begin
                if (filt_cnt == 4'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_sync[1];
                    filt_cnt <= '0;
                    fall     <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + 4'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Receive FSM plus inter-edge timeout. A fall event takes priority over an
    // expiring timeout, so a slow but legal edge still lands.
    always_ff @(posedge VGA_clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            scan_code  <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!data_sync[1]) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shift   <= {data_sync[1], shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= data_sync[1];
                        state   <= S_STOP;
                    end
                    default: begin
                        // Odd parity over the eight data bits plus the parity bit.
                        if (data_sync[1] && (^{shift, par_bit})) begin
                            scan_code  <= shift;
                            code_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end else if (state == S_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
        end
    end

    // Byte decoder: prefix flags and the one-hot request for this byte.
    always_comb begin
        req        = 4'b0000;
        break_next = break_flag;
        ext_next   = ext_flag;
        if (code_valid) begin
            if (scan_code == 8'hF0) begin
                break_next = 1'b1;
`ifdef PS2_ARROW_KEYS_EN
            end else if (scan_code == 8'hE0) begin
                ext_next = 1'b1;
`endif
            end else if (break_flag) begin
                // Release of a key (plain or extended): consume it and drop both prefixes.
                break_next = 1'b0;
                ext_next   = 1'b0;
            end else begin
                ext_next = 1'b0;
`ifdef PS2_ARROW_KEYS_EN
                if (ext_flag) begin
                    case (scan_code)
                        8'h75:   req = 4'b0001;
                        8'h6B:   req = 4'b0010;
                        8'h72:   req = 4'b0100;
                        8'h74:   req = 4'b1000;
                        default: req = 4'b0000;
                    endcase
                end else begin
                    case (scan_code)
                        8'h1D:   req = 4'b0001;
                        8'h1C:   req = 4'b0010;
                        8'h1B:   req = 4'b0100;
                        8'h23:   req = 4'b1000;
                        default: req = 4'b0000;
                    endcase
                end
`else
                case (scan_code)
                    8'h1D:   req = 4'b0001;
                    8'h1C:   req = 4'b0010;
                    8'h1B:   req = 4'b0100;
                    8'h23:   req = 4'b1000;
                    default: req = 4'b0000;
                endcase
`endif
            end
        end
    end

    // Bit order up/left/down/right puts each direction two places from its
    // opposite, so a 2-bit rotation yields the reversal to reject. From 0000 the
    // rotation is 0000, so any request is accepted.
    assign opposite = {direction[1:0], direction[3:2]};
    assign accept   = (req != 4'b0000) && (req != direction) && (req != opposite);

    always_ff @(posedge VGA_clk) begin
        if (!reset_n) begin
            direction  <= 4'b0000;
            key_valid  <= 1'b0;
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
        end else begin
            key_valid  <= 1'b0;
            break_flag <= break_next;
            ext_flag   <= ext_next;
            if (accept) begin
                direction <= req;
                key_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
module tb_ps2_direction_decoder;

`ifdef PS2_ARROW_KEYS_EN
    localparam bit ARROWS = 1'b1;
`else
    localparam bit ARROWS = 1'b0;
`endif
    localparam int HALF = 20;   // PS/2 half period in VGA_clk cycles

    logic       VGA_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       KB_clk  = 1'b1;
    logic       KB_data = 1'b1;
    logic [3:0] direction;
    logic       key_valid;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    ps2_direction_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(50000)) dut (
        .VGA_clk   (VGA_clk),
        .reset_n   (reset_n),
        .KB_clk    (KB_clk),
        .KB_data   (KB_data),
        .direction (direction),
        .key_valid (key_valid),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    always #20 VGA_clk = ~VGA_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_cv = 0, n_kv = 0, n_fe = 0;
    int cv_cyc = 0, kv_cyc = 0, fe_cyc = 0;
    int last_fall = 0;

    always @(negedge VGA_clk) begin
        cyc++;
        if (code_valid) begin n_cv++; cv_cyc = cyc; end
        if (key_valid)  begin n_kv++; kv_cyc = cyc; end
        if (frame_err)  begin n_fe++; fe_cyc = cyc; end
    end

    // Reference model: direction held as an index 0..3 (up,left,down,right), -1 = none.
    int         m_dir = -1;
    bit         m_brk = 1'b0;
    bit         m_ext = 1'b0;
    logic [7:0] m_scan = 8'h00;

    function automatic int code_idx(input logic [7:0] b, input bit ext);
        if (!ext) begin
            if (b == 8'h1D) return 0;
            if (b == 8'h1C) return 1;
            if (b == 8'h1B) return 2;
            if (b == 8'h23) return 3;
        end else begin
            if (b == 8'h75) return 0;
            if (b == 8'h6B) return 1;
            if (b == 8'h72) return 2;
            if (b == 8'h74) return 3;
        end
        return -1;
    endfunction

    function automatic logic [3:0] dir_vec(input int i);
        logic [3:0] v;
        v = 4'b0000;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // Applies one good byte to the model; returns 1 when a key_valid pulse is expected.
    function automatic bit model_byte(input logic [7:0] b);
        int i;
        m_scan = b;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (ARROWS && b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            i = code_idx(b, m_ext);
            m_ext = 1'b0;
            if (i >= 0 && (m_dir < 0 || (i != m_dir && i != (m_dir + 2) % 4))) begin
                m_dir = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge VGA_clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            KB_data = bits[i];
            half_period();
            KB_clk = 1'b0;
            last_fall = cyc;
            half_period();
            KB_clk = 1'b1;
        end
        KB_data = 1'b1;
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Sends one frame and checks every output against the model.
    task automatic do_frame(input string tag, input logic [7:0] b, input int corrupt);
        int cv0, kv0, fe0;
        bit exp_kv;
        cv0 = n_cv; kv0 = n_kv; fe0 = n_fe;
        send_bits(frame_of(b, corrupt == 1, corrupt == 2), 11);
        repeat (30) @(negedge VGA_clk);
        if (corrupt != 0) begin
            chk({tag, ":err"}, n_fe - fe0, 1);
            chk({tag, ":cv"}, n_cv - cv0, 0);
        end else begin
            exp_kv = model_byte(b);
            chk({tag, ":err"}, n_fe - fe0, 0);
            chk({tag, ":cv"}, n_cv - cv0, 1);
            chk({tag, ":cv_lat"}, (cv_cyc - last_fall >= 9) && (cv_cyc - last_fall <= 14), 1);
            chk({tag, ":kv"}, n_kv - kv0, exp_kv);
            if (exp_kv) chk({tag, ":kv_lat"}, kv_cyc - cv_cyc, 1);
        end
        chk({tag, ":scan"}, scan_code, m_scan);
        chk({tag, ":dir"}, direction, dir_vec(m_dir));
    endtask

    initial begin
        logic [7:0] tbl [12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hE0,
                                 8'h75, 8'h6B, 8'h72, 8'h74, 8'h12, 8'h29};
        int fe0, cv0, r;

        // Reset state
        repeat (10) @(negedge VGA_clk);
        chk("rst:dir", direction, 0);
        chk("rst:scan", scan_code, 0);
        chk("rst:kv", key_valid, 0);
        chk("rst:cv", code_valid, 0);
        chk("rst:err", frame_err, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge VGA_clk);

        // W, then reversal S ignored, then D accepted
        do_frame("w", 8'h1D, 0);
        chk("w:dir_up", direction, 4'b0001);
        do_frame("s_rev", 8'h1B, 0);
        do_frame("d", 8'h23, 0);

        // Parity error, then the same byte correctly
        do_frame("a_badpar", 8'h1C, 1);
        do_frame("a_good", 8'h1C, 0);

        // Key release F0 1C
        do_frame("brk_f0", 8'hF0, 0);
        do_frame("brk_a", 8'h1C, 0);

        // Timeout: start + 4 data bits, then the clock stays high
        fe0 = n_fe;
        send_bits(frame_of(8'h23, 1'b0, 1'b0), 5);
        repeat (52000) @(negedge VGA_clk);
        chk("to:err_cnt", n_fe - fe0, 1);
        chk("to:when", (fe_cyc - last_fall >= 50000) && (fe_cyc - last_fall <= 50040), 1);
        do_frame("to_next", 8'h23, 0);

        // 3-cycle glitches must never register as fall events
        fe0 = n_fe; cv0 = n_cv;
        KB_data = 1'b1;
        for (int g = 0; g < 6; g++) begin
            KB_clk = 1'b0;
            repeat (3) @(negedge VGA_clk);
            KB_clk = 1'b1;
            repeat (20) @(negedge VGA_clk);
        end
        chk("glitch:err", n_fe - fe0, 0);
        chk("glitch:cv", n_cv - cv0, 0);
        do_frame("glitch_next", 8'h1D, 0);

        // Reset in the middle of a frame: no error, everything cleared
        fe0 = n_fe;
        send_bits(frame_of(8'h1C, 1'b0, 1'b0), 4);
        reset_n = 1'b0;
        repeat (5) @(negedge VGA_clk);
        reset_n = 1'b1;
        m_dir = -1; m_brk = 1'b0; m_ext = 1'b0; m_scan = 8'h00;
        repeat (50) @(negedge VGA_clk);
        chk("midrst:err", n_fe - fe0, 0);
        chk("midrst:dir", direction, 0);
        chk("midrst:scan", scan_code, 0);

        // Extended prefix from 0000, then an extended break
        do_frame("e0", 8'hE0, 0);
        do_frame("e0_75", 8'h75, 0);
        do_frame("eb_e0", 8'hE0, 0);
        do_frame("eb_f0", 8'hF0, 0);
        do_frame("eb_72", 8'h72, 0);
        do_frame("after_eb_s", 8'h1B, 0);

        // Randomized frames against the model
        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 9));
            do_frame($sformatf("rnd%0d", k), tbl[$urandom_range(0, 11)],
                     (r == 0) ? 1 : ((r == 1) ? 2 : 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
